// File: rtl/ccu_wr_snoop_ctrl.sv
// CCU write path for one ACE port: snoops the peer cache for WriteUnique/WriteLineUnique, writes back dirty lines, forwards the write.
// One write in flight; AW accepted same cycle in IDLE, every later stage waits on its own valid/ready handshake.
module ccu_wr_snoop_ctrl #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CdBeats   = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             snoop_trs_i,
  input  logic                   slv_aw_valid,
  output logic                   slv_aw_ready,
  input  logic [IdWidth-1:0]     slv_aw_id,
  input  logic [AddrWidth-1:0]   slv_aw_addr,
  input  logic [7:0]             slv_aw_len,
  input  logic [2:0]             slv_aw_size,
  input  logic [1:0]             slv_aw_burst,
  input  logic [3:0]             slv_aw_cache,
  input  logic [2:0]             slv_aw_prot,
  input  logic [2:0]             slv_aw_snoop,
  input  logic [1:0]             slv_aw_domain,
  input  logic [1:0]             slv_aw_bar,
  input  logic                   slv_w_valid,
  output logic                   slv_w_ready,
  input  logic [DataWidth-1:0]   slv_w_data,
  input  logic [DataWidth/8-1:0] slv_w_strb,
  input  logic                   slv_w_last,
  output logic                   slv_b_valid,
  input  logic                   slv_b_ready,
  output logic [IdWidth-1:0]     slv_b_id,
  output logic [1:0]             slv_b_resp,
  output logic                   slv_ar_ready,
  output logic                   slv_r_valid,
  output logic                   mst_aw_valid,
  input  logic                   mst_aw_ready,
  output logic [IdWidth-1:0]     mst_aw_id,
  output logic [AddrWidth-1:0]   mst_aw_addr,
  output logic [7:0]             mst_aw_len,
  output logic [2:0]             mst_aw_size,
  output logic [1:0]             mst_aw_burst,
  output logic [3:0]             mst_aw_cache,
  output logic [2:0]             mst_aw_prot,
  output logic [2:0]             mst_aw_snoop,
  output logic [1:0]             mst_aw_domain,
  output logic [1:0]             mst_aw_bar,
  output logic                   mst_w_valid,
  input  logic                   mst_w_ready,
  output logic [DataWidth-1:0]   mst_w_data,
  output logic [DataWidth/8-1:0] mst_w_strb,
  output logic                   mst_w_last,
  input  logic                   mst_b_valid,
  output logic                   mst_b_ready,
  input  logic [IdWidth-1:0]     mst_b_id,
  input  logic [1:0]             mst_b_resp,
  output logic                   mst_ar_valid,
  output logic                   mst_r_ready,
  output logic                   ac_valid,
  input  logic                   ac_ready,
  output logic [AddrWidth-1:0]   ac_addr,
  output logic [3:0]             ac_snoop,
  output logic [2:0]             ac_prot,
  input  logic                   cr_valid,
  output logic                   cr_ready,
  input  logic [4:0]             cr_resp,
  input  logic                   cd_valid,
  output logic                   cd_ready,
  input  logic [DataWidth-1:0]   cd_data,
  input  logic                   cd_last
);

  localparam int unsigned LineOffs = $clog2(CdBeats * DataWidth / 8);
  localparam logic [2:0]  WbSize   = 3'($clog2(DataWidth / 8));
  localparam logic [7:0]  WbLen    = 8'(CdBeats - 1);

  typedef enum logic [3:0] {
    IDLE, SEND_AC, WAIT_CR, DRAIN_CD, WB_AW, WB_W, WB_B, FWD_AW, FWD_W, FWD_B
  } state_e;

  state_e state_q, state_d;

  logic [IdWidth-1:0]   aw_id_q;
  logic [AddrWidth-1:0] aw_addr_q;
  logic [7:0]           aw_len_q;
  logic [2:0]           aw_size_q, aw_prot_q, aw_snoop_q;
  logic [1:0]           aw_burst_q, aw_domain_q, aw_bar_q;
  logic [3:0]           aw_cache_q, acsnoop_q;
  logic                 snoop_req;

  assign snoop_req = (slv_aw_domain == 2'b01 || slv_aw_domain == 2'b10) &&
                     (slv_aw_snoop == 3'b000 || slv_aw_snoop == 3'b001);

  assign slv_ar_ready = 1'b0;
  assign slv_r_valid  = 1'b0;
  assign mst_ar_valid = 1'b0;
  assign mst_r_ready  = 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_id_q     <= '0;
      aw_addr_q   <= '0;
      aw_len_q    <= '0;
      aw_size_q   <= '0;
      aw_burst_q  <= '0;
      aw_cache_q  <= '0;
      aw_prot_q   <= '0;
      aw_snoop_q  <= '0;
      aw_domain_q <= '0;
      aw_bar_q    <= '0;
      acsnoop_q   <= '0;
    end else if (state_q == IDLE && slv_aw_valid) begin
      aw_id_q     <= slv_aw_id;
      aw_addr_q   <= slv_aw_addr;
      aw_len_q    <= slv_aw_len;
      aw_size_q   <= slv_aw_size;
      aw_burst_q  <= slv_aw_burst;
      aw_cache_q  <= slv_aw_cache;
      aw_prot_q   <= slv_aw_prot;
      aw_snoop_q  <= slv_aw_snoop;
      aw_domain_q <= slv_aw_domain;
      aw_bar_q    <= slv_aw_bar;
      acsnoop_q   <= snoop_trs_i;
    end
  end

  always_comb begin
    state_d       = state_q;
    slv_aw_ready  = 1'b0;
    slv_w_ready   = 1'b0;
    slv_b_valid   = 1'b0;
    slv_b_id      = '0;
    slv_b_resp    = '0;
    mst_aw_valid  = 1'b0;
    mst_aw_id     = '0;
    mst_aw_addr   = '0;
    mst_aw_len    = '0;
    mst_aw_size   = '0;
    mst_aw_burst  = '0;
    mst_aw_cache  = '0;
    mst_aw_prot   = '0;
    mst_aw_snoop  = '0;
    mst_aw_domain = '0;
    mst_aw_bar    = '0;
    mst_w_valid   = 1'b0;
    mst_w_data    = '0;
    mst_w_strb    = '0;
    mst_w_last    = 1'b0;
    mst_b_ready   = 1'b0;
    ac_valid      = 1'b0;
    ac_addr       = '0;
    ac_snoop      = '0;
    ac_prot       = '0;
    cr_ready      = 1'b0;
    cd_ready      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated so the AW ready stays low while reset is held.
        slv_aw_ready = slv_aw_valid & ~rst_i;
        if (slv_aw_valid) state_d = snoop_req ? SEND_AC : FWD_AW;
      end
      SEND_AC: begin
        ac_valid = 1'b1;
        ac_addr  = aw_addr_q;
        ac_snoop = acsnoop_q;
        ac_prot  = aw_prot_q;
        if (ac_ready) state_d = WAIT_CR;
      end
      WAIT_CR: begin
        cr_ready = 1'b1;
        if (cr_valid) begin
          casez (cr_resp)
            5'b??1?1: state_d = WB_AW;     // DataTransfer + PassDirty
            5'b????1: state_d = DRAIN_CD;  // clean data, nothing to keep
            default:  state_d = FWD_AW;
          endcase
        end
      end
      DRAIN_CD: begin
        cd_ready = 1'b1;
        if (cd_valid && cd_last) state_d = FWD_AW;
      end
      WB_AW: begin
        mst_aw_valid = 1'b1;
        mst_aw_id    = aw_id_q;
        mst_aw_addr  = {aw_addr_q[AddrWidth-1:LineOffs], {LineOffs{1'b0}}};
        mst_aw_len   = WbLen;
        mst_aw_size  = WbSize;
        mst_aw_burst = 2'b01;
        mst_aw_cache = aw_cache_q;
        mst_aw_prot  = aw_prot_q;
        if (mst_aw_ready) state_d = WB_W;
      end
      WB_W: begin
        mst_w_valid = cd_valid;
        cd_ready    = mst_w_ready;
        mst_w_data  = cd_data;
        mst_w_strb  = '1;
        mst_w_last  = cd_last;
        if (cd_valid && mst_w_ready && cd_last) state_d = WB_B;
      end
      WB_B: begin
        mst_b_ready = 1'b1;
        if (mst_b_valid) state_d = FWD_AW;
      end
      FWD_AW: begin
        mst_aw_valid  = 1'b1;
        mst_aw_id     = aw_id_q;
        mst_aw_addr   = aw_addr_q;
        mst_aw_len    = aw_len_q;
        mst_aw_size   = aw_size_q;
        mst_aw_burst  = aw_burst_q;
        mst_aw_cache  = aw_cache_q;
        mst_aw_prot   = aw_prot_q;
        mst_aw_snoop  = aw_snoop_q;
        mst_aw_domain = aw_domain_q;
        mst_aw_bar    = aw_bar_q;
        if (mst_aw_ready) state_d = FWD_W;
      end
      FWD_W: begin
        mst_w_valid = slv_w_valid;
        mst_w_data  = slv_w_data;
        mst_w_strb  = slv_w_strb;
        mst_w_last  = slv_w_last;
        slv_w_ready = mst_w_ready;
        if (slv_w_valid && mst_w_ready && slv_w_last) state_d = FWD_B;
      end
      FWD_B: begin
        slv_b_valid = mst_b_valid;
        slv_b_id    = mst_b_id;
        slv_b_resp  = mst_b_resp;
        mst_b_ready = slv_b_ready;
        if (mst_b_valid && slv_b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ccu_wr_snoop_ctrl.sv
// Directed bench for ccu_wr_snoop_ctrl: the bench plays master, snooped cache and memory in one sequence.
`define WAIT_HI(sig, tag) begin int n_ = 0; #1; while (!(sig) && n_ < 40) begin @(negedge clk_i); #1; n_++; end chk(tag, 64'(sig), 64'(1)); end

module tb_ccu_wr_snoop_ctrl;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [3:0] snoop_trs_i;
  logic slv_aw_valid, slv_aw_ready;
  logic [IW-1:0] slv_aw_id;
  logic [AW-1:0] slv_aw_addr;
  logic [7:0] slv_aw_len;
  logic [2:0] slv_aw_size, slv_aw_prot, slv_aw_snoop;
  logic [1:0] slv_aw_burst, slv_aw_domain, slv_aw_bar;
  logic [3:0] slv_aw_cache;
  logic slv_w_valid, slv_w_ready, slv_w_last;
  logic [DW-1:0] slv_w_data;
  logic [DW/8-1:0] slv_w_strb;
  logic slv_b_valid, slv_b_ready;
  logic [IW-1:0] slv_b_id;
  logic [1:0] slv_b_resp;
  logic slv_ar_ready, slv_r_valid;
  logic mst_aw_valid, mst_aw_ready;
  logic [IW-1:0] mst_aw_id;
  logic [AW-1:0] mst_aw_addr;
  logic [7:0] mst_aw_len;
  logic [2:0] mst_aw_size, mst_aw_prot, mst_aw_snoop;
  logic [1:0] mst_aw_burst, mst_aw_domain, mst_aw_bar;
  logic [3:0] mst_aw_cache;
  logic mst_w_valid, mst_w_ready, mst_w_last;
  logic [DW-1:0] mst_w_data;
  logic [DW/8-1:0] mst_w_strb;
  logic mst_b_valid, mst_b_ready;
  logic [IW-1:0] mst_b_id;
  logic [1:0] mst_b_resp;
  logic mst_ar_valid, mst_r_ready;
  logic ac_valid, ac_ready;
  logic [AW-1:0] ac_addr;
  logic [3:0] ac_snoop;
  logic [2:0] ac_prot;
  logic cr_valid, cr_ready;
  logic [4:0] cr_resp;
  logic cd_valid, cd_ready, cd_last;
  logic [DW-1:0] cd_data;

  ccu_wr_snoop_ctrl #(.DataWidth(DW), .CdBeats(4), .AddrWidth(AW), .IdWidth(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .snoop_trs_i(snoop_trs_i),
    .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready), .slv_aw_id(slv_aw_id),
    .slv_aw_addr(slv_aw_addr), .slv_aw_len(slv_aw_len), .slv_aw_size(slv_aw_size),
    .slv_aw_burst(slv_aw_burst), .slv_aw_cache(slv_aw_cache), .slv_aw_prot(slv_aw_prot),
    .slv_aw_snoop(slv_aw_snoop), .slv_aw_domain(slv_aw_domain), .slv_aw_bar(slv_aw_bar),
    .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready), .slv_w_data(slv_w_data),
    .slv_w_strb(slv_w_strb), .slv_w_last(slv_w_last),
    .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready), .slv_b_id(slv_b_id), .slv_b_resp(slv_b_resp),
    .slv_ar_ready(slv_ar_ready), .slv_r_valid(slv_r_valid),
    .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready), .mst_aw_id(mst_aw_id),
    .mst_aw_addr(mst_aw_addr), .mst_aw_len(mst_aw_len), .mst_aw_size(mst_aw_size),
    .mst_aw_burst(mst_aw_burst), .mst_aw_cache(mst_aw_cache), .mst_aw_prot(mst_aw_prot),
    .mst_aw_snoop(mst_aw_snoop), .mst_aw_domain(mst_aw_domain), .mst_aw_bar(mst_aw_bar),
    .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready), .mst_w_data(mst_w_data),
    .mst_w_strb(mst_w_strb), .mst_w_last(mst_w_last),
    .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready), .mst_b_id(mst_b_id), .mst_b_resp(mst_b_resp),
    .mst_ar_valid(mst_ar_valid), .mst_r_ready(mst_r_ready),
    .ac_valid(ac_valid), .ac_ready(ac_ready), .ac_addr(ac_addr), .ac_snoop(ac_snoop), .ac_prot(ac_prot),
    .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_resp(cr_resp),
    .cd_valid(cd_valid), .cd_ready(cd_ready), .cd_data(cd_data), .cd_last(cd_last)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;
  int ac_hs = 0, maw_hs = 0, mw_hs = 0, sb_hs = 0;
  logic [63:0] mem     [logic [31:0]];
  logic [63:0] exp_mem [logic [31:0]];

  // Handshake counters, sampled just before each rising edge once inputs are settled.
  always begin
    @(negedge clk_i);
    #4;
    if (!rst_i) begin
      if (ac_valid && ac_ready) ac_hs++;
      if (mst_aw_valid && mst_aw_ready) maw_hs++;
      if (mst_w_valid && mst_w_ready) mw_hs++;
      if (slv_b_valid && slv_b_ready) sb_hs++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic hold(input int d);
    repeat (d) @(negedge clk_i);
  endtask

  function automatic int rdly(input int maxd);
    return int'($urandom_range(0, unsigned'(maxd)));
  endfunction

  task automatic run_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] snp, input logic [1:0] dom, input logic [3:0] acs,
                           input logic [4:0] crr, input logic [63:0] dbase, input logic [63:0] cbase,
                           input int maxd, input bit abort_wb);
    bit snoop_exp, wb_exp, drain_exp;
    int ac0, aw0, w0, b0;
    logic [AW-1:0] wb_addr, cur;
    snoop_exp = (dom == 2'b01 || dom == 2'b10) && (snp == 3'b000 || snp == 3'b001);
    wb_exp    = snoop_exp && crr[0] && crr[2];
    drain_exp = snoop_exp && crr[0] && !crr[2];
    wb_addr   = addr & ~32'h1F;
    ac0 = ac_hs; aw0 = maw_hs; w0 = mw_hs; b0 = sb_hs;

    slv_aw_valid = 1'b1; slv_aw_id = id; slv_aw_addr = addr; slv_aw_len = len;
    slv_aw_size = 3'd3; slv_aw_burst = 2'b01; slv_aw_cache = 4'h3; slv_aw_prot = 3'b010;
    slv_aw_snoop = snp; slv_aw_domain = dom; slv_aw_bar = 2'b00; snoop_trs_i = acs;
    #1;
    chk("slv_aw_ready", 64'(slv_aw_ready), 64'(1));
    cyc();
    slv_aw_valid = 1'b0; slv_aw_addr = '0; snoop_trs_i = '0;

    if (snoop_exp) begin
      `WAIT_HI(ac_valid, "ac_valid")
      chk("ac_addr", 64'(ac_addr), 64'(addr));
      chk("ac_snoop", 64'(ac_snoop), 64'(acs));
      chk("ac_prot", 64'(ac_prot), 64'(3'b010));
      hold(rdly(maxd));
      ac_ready = 1'b1;
      #1;
      chk("ac_addr_held", 64'(ac_addr), 64'(addr));
      cyc();
      ac_ready = 1'b0;
      hold(rdly(maxd));
      cr_valid = 1'b1; cr_resp = crr;
      #1;
      chk("cr_ready", 64'(cr_ready), 64'(1));
      chk("ac_single", 64'(ac_valid), 64'(0));
      cyc();
      cr_valid = 1'b0; cr_resp = '0;
      if (drain_exp) begin
        for (int b = 0; b < 4; b++) begin
          cd_valid = 1'b1; cd_data = cbase + 64'(b); cd_last = (b == 3);
          #1;
          chk("drain_cd_ready", 64'(cd_ready), 64'(1));
          chk("drain_no_mst_w", 64'(mst_w_valid), 64'(0));
          cyc();
        end
        cd_valid = 1'b0; cd_last = 1'b0;
      end
      if (wb_exp) begin
        `WAIT_HI(mst_aw_valid, "wb_aw_valid")
        chk("wb_aw_addr", 64'(mst_aw_addr), 64'(wb_addr));
        chk("wb_aw_len", 64'(mst_aw_len), 64'(3));
        chk("wb_aw_size", 64'(mst_aw_size), 64'(3));
        chk("wb_aw_burst", 64'(mst_aw_burst), 64'(1));
        chk("wb_aw_id", 64'(mst_aw_id), 64'(id));
        hold(rdly(maxd));
        mst_aw_ready = 1'b1;
        cyc();
        mst_aw_ready = 1'b0;
        cur = wb_addr;
        for (int b = 0; b < 4; b++) begin
          cd_valid = 1'b1; cd_data = cbase + 64'(b); cd_last = (b == 3);
          hold(rdly(maxd));
          mst_w_ready = 1'b1;
          #1;
          if (abort_wb && b == 1) begin
            rst_i = 1'b1;
            #1;
            chk("rst_mst_w_valid", 64'(mst_w_valid), 64'(0));
            chk("rst_cd_ready", 64'(cd_ready), 64'(0));
            chk("rst_mst_aw_valid", 64'(mst_aw_valid), 64'(0));
            chk("rst_mst_b_ready", 64'(mst_b_ready), 64'(0));
            chk("rst_mst_w_data", mst_w_data, 64'(0));
            cyc();
            cd_valid = 1'b0; cd_last = 1'b0; mst_w_ready = 1'b0;
            cyc();
            rst_i = 1'b0;
            cyc();
            return;
          end
          chk("wb_w_valid", 64'(mst_w_valid), 64'(1));
          chk("wb_w_data", mst_w_data, cbase + 64'(b));
          chk("wb_w_last", 64'(mst_w_last), 64'(b == 3));
          chk("wb_w_strb", 64'(mst_w_strb), 64'(8'hFF));
          chk("wb_cd_ready", 64'(cd_ready), 64'(1));
          chk("wb_slv_w_ready", 64'(slv_w_ready), 64'(0));
          mem[cur + 32'(8 * b)] = mst_w_data;
          exp_mem[wb_addr + 32'(8 * b)] = cbase + 64'(b);
          cyc();
          mst_w_ready = 1'b0;
        end
        cd_valid = 1'b0; cd_last = 1'b0;
        hold(rdly(maxd));
        mst_b_valid = 1'b1; mst_b_id = id; mst_b_resp = 2'b00;
        #1;
        chk("wb_b_ready", 64'(mst_b_ready), 64'(1));
        chk("wb_b_hidden", 64'(slv_b_valid), 64'(0));
        cyc();
        mst_b_valid = 1'b0;
      end
    end

    `WAIT_HI(mst_aw_valid, "fwd_aw_valid")
    chk("fwd_aw_addr", 64'(mst_aw_addr), 64'(addr));
    chk("fwd_aw_id", 64'(mst_aw_id), 64'(id));
    chk("fwd_aw_len", 64'(mst_aw_len), 64'(len));
    chk("fwd_aw_snoop", 64'(mst_aw_snoop), 64'(snp));
    chk("fwd_aw_domain", 64'(mst_aw_domain), 64'(dom));
    chk("fwd_aw_prot", 64'(mst_aw_prot), 64'(3'b010));
    hold(rdly(maxd));
    mst_aw_ready = 1'b1;
    cyc();
    mst_aw_ready = 1'b0;
    cur = addr;
    for (int b = 0; b <= int'(len); b++) begin
      slv_w_valid = 1'b1; slv_w_data = dbase + 64'(b); slv_w_strb = 8'hFF; slv_w_last = (b == int'(len));
      hold(rdly(maxd));
      mst_w_ready = 1'b1;
      #1;
      chk("fwd_w_valid", 64'(mst_w_valid), 64'(1));
      chk("fwd_w_data", mst_w_data, dbase + 64'(b));
      chk("fwd_w_last", 64'(mst_w_last), 64'(b == int'(len)));
      chk("fwd_slv_w_ready", 64'(slv_w_ready), 64'(1));
      mem[cur + 32'(8 * b)] = mst_w_data;
      exp_mem[addr + 32'(8 * b)] = dbase + 64'(b);
      cyc();
      mst_w_ready = 1'b0;
    end
    slv_w_valid = 1'b0; slv_w_last = 1'b0;

    hold(rdly(maxd));
    mst_b_valid = 1'b1; mst_b_id = id; mst_b_resp = 2'b00; slv_b_ready = 1'b0;
    #1;
    chk("slv_b_valid", 64'(slv_b_valid), 64'(1));
    chk("slv_b_id", 64'(slv_b_id), 64'(id));
    chk("slv_b_resp", 64'(slv_b_resp), 64'(0));
    hold(rdly(maxd));
    slv_b_ready = 1'b1;
    #1;
    chk("mst_b_ready_fwd", 64'(mst_b_ready), 64'(1));
    cyc();
    mst_b_valid = 1'b0; slv_b_ready = 1'b0;

    chk("ac_count", 64'(ac_hs - ac0), 64'(snoop_exp));
    chk("mst_aw_count", 64'(maw_hs - aw0), 64'(wb_exp ? 2 : 1));
    chk("mst_w_count", 64'(mw_hs - w0), 64'((wb_exp ? 4 : 0) + int'(len) + 1));
    chk("slv_b_count", 64'(sb_hs - b0), 64'(1));
  endtask

  initial begin
    logic [4:0] crr_tab [5];
    logic [1:0] r_dom;
    logic [2:0] r_snp;
    logic [AW-1:0] r_addr;
    crr_tab[0] = 5'b00000; crr_tab[1] = 5'b00001; crr_tab[2] = 5'b00101;
    crr_tab[3] = 5'b00100; crr_tab[4] = 5'b01101;

    rst_i = 1'b1; snoop_trs_i = '0;
    slv_aw_valid = 1'b1; slv_aw_id = '0; slv_aw_addr = '0; slv_aw_len = '0; slv_aw_size = '0;
    slv_aw_burst = '0; slv_aw_cache = '0; slv_aw_prot = '0; slv_aw_snoop = '0; slv_aw_domain = '0;
    slv_aw_bar = '0; slv_w_valid = 1'b0; slv_w_data = '0; slv_w_strb = '0; slv_w_last = 1'b0;
    slv_b_ready = 1'b0; mst_aw_ready = 1'b0; mst_w_ready = 1'b0; mst_b_valid = 1'b0;
    mst_b_id = '0; mst_b_resp = '0; ac_ready = 1'b0; cr_valid = 1'b0; cr_resp = '0;
    cd_valid = 1'b0; cd_data = '0; cd_last = 1'b0;

    cyc();
    #1;
    chk("rst_slv_aw_ready", 64'(slv_aw_ready), 64'(0));
    chk("rst_ac_valid", 64'(ac_valid), 64'(0));
    chk("rst_mst_aw_valid", 64'(mst_aw_valid), 64'(0));
    chk("rst_mst_aw_addr", 64'(mst_aw_addr), 64'(0));
    chk("rst_slv_b_valid", 64'(slv_b_valid), 64'(0));
    chk("rst_cr_cd_ready", 64'({cr_ready, cd_ready}), 64'(0));
    chk("rst_read_chans", 64'({slv_ar_ready, slv_r_valid, mst_ar_valid, mst_r_ready}), 64'(0));
    slv_aw_valid = 1'b0;
    cyc();
    rst_i = 1'b0;
    cyc();

    // WriteNoSnoop, WriteUnique with no data, dirty write-back, clean drain
    run_write(4'd3, 32'h100, 8'd0, 3'b000, 2'b00, 4'b0000, 5'b00000, 64'hDEAD, 64'h0, 0, 1'b0);
    chk("mem_nosnoop", mem[32'h100], 64'hDEAD);
    run_write(4'd5, 32'h2048, 8'd1, 3'b000, 2'b01, 4'b1001, 5'b00000, 64'hA0, 64'h0, 0, 1'b0);
    run_write(4'd6, 32'h3038, 8'd0, 3'b000, 2'b01, 4'b1001, 5'b00101, 64'hBEEF, 64'h1, 0, 1'b0);
    chk("mem_wb_beat1", mem[32'h3020], 64'h1);
    chk("mem_wb_beat3", mem[32'h3030], 64'h3);
    chk("mem_fwd_over_wb", mem[32'h3038], 64'hBEEF);
    run_write(4'd7, 32'h4000, 8'd3, 3'b001, 2'b10, 4'b1001, 5'b00001, 64'hC0, 64'h50, 0, 1'b0);
    chk("mem_clean_not_written", 64'(mem.exists(32'h4000) ? mem[32'h4000] : 64'hX), 64'hC0);

    // back-pressure on every handshake over 80 mixed writes
    for (int i = 0; i < 80; i++) begin
      r_dom  = 2'($urandom_range(0, 3));
      r_snp  = 3'($urandom_range(0, 3));
      r_addr = 32'h8000 + 32'(8 * $urandom_range(0, 31));
      run_write(4'(i), r_addr, 8'($urandom_range(0, 3)), r_snp, r_dom, 4'($urandom_range(0, 15)),
                crr_tab[$urandom_range(0, 4)], 64'(i) << 16, (64'(i) << 16) | 64'hF000, 5, 1'b0);
    end
    chk("mem_size", 64'(mem.size()), 64'(exp_mem.size()));
    foreach (exp_mem[a]) chk("mem_contents", mem.exists(a) ? mem[a] : 64'hX, exp_mem[a]);

    // reset in the middle of a write-back, then a clean transaction
    run_write(4'd9, 32'h5000, 8'd0, 3'b000, 2'b01, 4'b1001, 5'b00101, 64'h77, 64'h900, 0, 1'b1);
    run_write(4'd2, 32'h6000, 8'd0, 3'b000, 2'b00, 4'b0000, 5'b00000, 64'h1234, 64'h0, 0, 1'b0);
    chk("mem_after_reset", mem[32'h6000], 64'h1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
